// File: rtl/ram_arb_pkg.sv
// Shared constants for the fetch/memory-stage RAM arbiter.
package ram_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_MEM   = 1'b1;

    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester ports and RAM-side bus of the arbiter; slave is the arbiter's view.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic        req_trig_0, req_trig_1;
    logic [31:0] addr_0, addr_1;
    logic [31:0] wdata_0, wdata_1;
    logic        rw_0, rw_1;
    logic [31:0] rdata_0, rdata_1;
    logic        ack_trig_0, ack_trig_1;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_rw;
    logic        ram_trig;
    logic        ram_done;
    logic [31:0] ram_rdata;
    logic        err_timeout;

    modport slave (
        input  req_trig_0, req_trig_1, addr_0, addr_1, wdata_0, wdata_1, rw_0, rw_1,
        input  ram_done, ram_rdata,
        output rdata_0, rdata_1, ack_trig_0, ack_trig_1,
        output ram_addr, ram_wdata, ram_rw, ram_trig, err_timeout
    );

    modport master (
        output req_trig_0, req_trig_1, addr_0, addr_1, wdata_0, wdata_1, rw_0, rw_1,
        output ram_done, ram_rdata,
        input  rdata_0, rdata_1, ack_trig_0, ack_trig_1,
        input  ram_addr, ram_wdata, ram_rw, ram_trig, err_timeout
    );

endinterface

// File: rtl/toggle_sync.sv
// Multi-flop synchronizer for a toggle-encoded handshake wire.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (reset) chain_q <= '0;
        else       chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
    end

    assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-port toggle-handshake arbiter sharing one RAM: memory stage has priority,
// fetch is protected by a starvation guard, and a silent RAM is timed out.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_CONSEC  = 4,
    parameter int TIMEOUT     = 1024
) (
    input logic         clk,
    input logic         reset,
    ram_arbiter_if.slave bus
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SCW = $clog2(MAX_CONSEC + 1);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(MAX_CONSEC);

    logic [1:0] req_s;
    logic       done_s;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req0 (
        .clk(clk), .reset(reset), .d_i(bus.req_trig_0), .q_o(req_s[0]));
    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req1 (
        .clk(clk), .reset(reset), .d_i(bus.req_trig_1), .q_o(req_s[1]));
    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_done (
        .clk(clk), .reset(reset), .d_i(bus.ram_done), .q_o(done_s));

    logic [1:0]     state_q, state_d;
    logic           gnt_q, gnt_d;
    logic [1:0]     seen_q, seen_d;
    logic [1:0]     ack_q, ack_d;
    logic [SCW-1:0] starve_q, starve_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           stale_q, stale_d;
    logic [31:0]    ram_addr_q, ram_addr_d;
    logic [31:0]    ram_wdata_q, ram_wdata_d;
    logic           ram_rw_q, ram_rw_d;
    logic           ram_trig_q, ram_trig_d;
    logic [31:0]    rdata0_q, rdata0_d;
    logic [31:0]    rdata1_q, rdata1_d;
    logic           err_q, err_d;

    logic [1:0] pending;
    logic       done_match;
    logic       grant;

    assign pending    = req_s ^ seen_q;
    assign done_match = (done_s == ram_trig_q);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        seen_d      = seen_q;
        ack_d       = ack_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        stale_d     = stale_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_rw_d    = ram_rw_q;
        ram_trig_d  = ram_trig_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        err_d       = 1'b0;
        grant       = PORT_FETCH;

        if (!pending[0]) starve_d = '0;

        case (state_q)
            IDLE: begin
                // After a timeout, hold off new grants until the late completion drains.
                if (stale_q) begin
                    if (done_match) stale_d = 1'b0;
                end else if (|pending) begin
                    grant = (pending[1] && !(pending[0] && starve_q == STARVE_MAX))
                            ? PORT_MEM : PORT_FETCH;
                    gnt_d       = grant;
                    ram_addr_d  = grant ? bus.addr_1  : bus.addr_0;
                    ram_wdata_d = grant ? bus.wdata_1 : bus.wdata_0;
                    ram_rw_d    = grant ? bus.rw_1    : bus.rw_0;
                    if (grant == PORT_MEM && pending[0]) starve_d = starve_q + SCW'(1);
                    else                                 starve_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ram_trig_d = ~ram_trig_q;
                wait_d     = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (done_match) begin
                    if (!ram_rw_q) begin
                        if (gnt_q) rdata1_d = bus.ram_rdata;
                        else       rdata0_d = bus.ram_rdata;
                    end
                    state_d = RESP;
                end else if (wait_q == WAIT_LAST) begin
                    if (!ram_rw_q) begin
                        if (gnt_q) rdata1_d = TIMEOUT_RDATA;
                        else       rdata0_d = TIMEOUT_RDATA;
                    end
                    stale_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            RESP: begin
                ack_d[gnt_q]  = ~ack_q[gnt_q];
                seen_d[gnt_q] = ~seen_q[gnt_q];
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            seen_q      <= '0;
            ack_q       <= '0;
            starve_q    <= '0;
            wait_q      <= '0;
            stale_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_rw_q    <= 1'b0;
            ram_trig_q  <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            seen_q      <= seen_d;
            ack_q       <= ack_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            stale_q     <= stale_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_rw_q    <= ram_rw_d;
            ram_trig_q  <= ram_trig_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            err_q       <= err_d;
        end
    end

    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.ram_rw      = ram_rw_q;
    assign bus.ram_trig    = ram_trig_q;
    assign bus.ack_trig_0  = ack_q[0];
    assign bus.ack_trig_1  = ack_q[1];
    assign bus.rdata_0     = rdata0_q;
    assign bus.rdata_1     = rdata1_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios, then randomized traffic checked
// against a per-address reference memory.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset;
    logic rst_q;

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= reset;

    ram_arbiter_if bus();

    ram_arbiter #(.SYNC_STAGES(2), .MAX_CONSEC(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // RAM model controls (written by the main sequence)
    int   ram_lat;
    logic ram_silent;
    int   force_req;

    // RAM model state and transaction log (written by the RAM model only)
    int          log_n = 0;
    logic [31:0] lg_addr  [256];
    logic [31:0] lg_wdata [256];
    logic        lg_rw    [256];
    logic [31:0] dev_mem  [logic [31:0]];
    logic        ram_last_trig, ram_pend;
    int          ram_cnt, force_seen;
    logic [31:0] op_addr, op_wdata, prev_addr, prev_wdata;
    logic        op_rw, prev_rw;

    logic        ack_exp [2];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] fill_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input int p, input logic rw, input logic [31:0] a, input logic [31:0] wd);
        if (p == 1) begin
            bus.rw_1 = rw; bus.addr_1 = a; bus.wdata_1 = wd;
            bus.req_trig_1 = ~bus.req_trig_1;
        end else begin
            bus.rw_0 = rw; bus.addr_0 = a; bus.wdata_0 = wd;
            bus.req_trig_0 = ~bus.req_trig_0;
        end
    endtask

    task automatic wait_ack(input int p, input string tag);
        int   n;
        logic lvl;
        n   = 0;
        lvl = (p == 1) ? bus.ack_trig_1 : bus.ack_trig_0;
        while (lvl === ack_exp[p] && n < 300) begin
            @(negedge clk);
            n++;
            lvl = (p == 1) ? bus.ack_trig_1 : bus.ack_trig_0;
        end
        chk1({tag, "_ack"}, lvl, ~ack_exp[p]);
        ack_exp[p] = ~ack_exp[p];
    endtask

    task automatic wait_trig(input logic lvl0, input string tag);
        int n;
        n = 0;
        while (bus.ram_trig === lvl0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, "_trig"}, bus.ram_trig, ~lvl0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk1({tag, "_ack0"},  bus.ack_trig_0, 1'b0);
        chk1({tag, "_ack1"},  bus.ack_trig_1, 1'b0);
        chk ({tag, "_rd0"},   bus.rdata_0, 32'h0);
        chk ({tag, "_rd1"},   bus.rdata_1, 32'h0);
        chk ({tag, "_raddr"}, bus.ram_addr, 32'h0);
        chk ({tag, "_rwd"},   bus.ram_wdata, 32'h0);
        chk1({tag, "_rrw"},   bus.ram_rw, 1'b0);
        chk1({tag, "_rtrig"}, bus.ram_trig, 1'b0);
        chk1({tag, "_err"},   bus.err_timeout, 1'b0);
        chk ({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
    endtask

    // RAM: completes each request ram_lat cycles after its toggle, unless silent
    initial begin : ram_model
        bus.ram_done  = 1'b0;
        bus.ram_rdata = '0;
        ram_last_trig = 1'b0;
        ram_pend      = 1'b0;
        ram_cnt       = 0;
        force_seen    = 0;
        prev_addr     = '0;
        prev_wdata    = '0;
        prev_rw       = 1'b0;
        dev_mem[32'h100] = 32'h1234_5678;
        dev_mem[32'h104] = 32'hCAFE_F00D;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                bus.ram_done  = 1'b0;
                ram_last_trig = 1'b0;
                ram_pend      = 1'b0;
                force_seen    = force_req;
            end else begin
                if (force_req != force_seen) begin
                    force_seen   = force_req;
                    bus.ram_done = ~bus.ram_done;
                end
                if (bus.ram_trig !== ram_last_trig) begin
                    ram_last_trig   = bus.ram_trig;
                    lg_addr[log_n]  = prev_addr;
                    lg_wdata[log_n] = prev_wdata;
                    lg_rw[log_n]    = prev_rw;
                    log_n++;
                    op_addr  = bus.ram_addr;
                    op_wdata = bus.ram_wdata;
                    op_rw    = bus.ram_rw;
                    ram_pend = !ram_silent;
                    ram_cnt  = ram_lat;
                end else if (ram_pend) begin
                    ram_cnt--;
                    if (ram_cnt <= 0) begin
                        if (op_rw) dev_mem[op_addr] = op_wdata;
                        else bus.ram_rdata = dev_mem.exists(op_addr) ? dev_mem[op_addr]
                                                                     : fill_word(op_addr);
                        bus.ram_done = ~bus.ram_done;
                        ram_pend     = 1'b0;
                    end
                end
            end
            prev_addr  = bus.ram_addr;
            prev_wdata = bus.ram_wdata;
            prev_rw    = bus.ram_rw;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          base, n;
        logic        lvl, rw;
        logic [31:0] a, wd;
        logic [31:0] exp_rd [2];
        logic        go [2];
        logic [31:0] exp_seq [6];

        reset = 1'b1;
        bus.req_trig_0 = 1'b0; bus.req_trig_1 = 1'b0;
        bus.addr_0 = '0; bus.addr_1 = '0; bus.wdata_0 = '0; bus.wdata_1 = '0;
        bus.rw_0 = 1'b0; bus.rw_1 = 1'b0;
        ram_lat = 5; ram_silent = 1'b0; force_req = 0;
        ack_exp[0] = 1'b0; ack_exp[1] = 1'b0;
        cyc(3);
        chk_zero_outputs("reset");
        reset = 1'b0;
        cyc(2);

        // Single read on the memory-stage port
        base = log_n;
        issue(1, 1'b0, 32'h100, 32'h0);
        wait_ack(1, "rd1");
        chk ("rd1_rdata", bus.rdata_1, 32'h1234_5678);
        chk ("rd1_ntrig", 32'(log_n - base), 32'd1);
        chk ("rd1_addr_pre", lg_addr[base], 32'h100);
        chk1("rd1_rw_pre", lg_rw[base], 1'b0);
        cyc(6);
        chk1("rd1_ack_once", bus.ack_trig_1, ack_exp[1]);

        // Write on the fetch port
        base = log_n;
        issue(0, 1'b1, 32'h20, 32'hA5A5_A5A5);
        wait_ack(0, "wr0");
        chk1("wr0_rw_pre", lg_rw[base], 1'b1);
        chk ("wr0_wdata_pre", lg_wdata[base], 32'hA5A5_A5A5);
        chk ("wr0_addr_pre", lg_addr[base], 32'h20);
        chk ("wr0_rdata_kept", bus.rdata_0, 32'h0);

        // Both ports toggle in the same cycle
        base = log_n;
        issue(1, 1'b0, 32'h100, 32'h0);
        issue(0, 1'b0, 32'h20, 32'h0);
        wait_ack(1, "cont1");
        wait_ack(0, "cont0");
        cyc(4);
        chk("cont_ntrig", 32'(log_n - base), 32'd2);
        chk("cont_first", lg_addr[base], 32'h100);
        chk("cont_second", lg_addr[base + 1], 32'h20);
        chk("cont_rd1", bus.rdata_1, 32'h1234_5678);
        chk("cont_rd0", bus.rdata_0, 32'hA5A5_A5A5);

        // Starvation guard: port 1 re-toggles during each WAIT so it is pending
        // again in the IDLE cycle after its RESP, while port 0 stays pending.
        base = log_n;
        lvl  = bus.ram_trig;
        issue(1, 1'b0, 32'h100, 32'h0);
        issue(0, 1'b0, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_trig(lvl, "stv");
            lvl = ~lvl;
            issue(1, 1'b0, 32'h100, 32'h0);
        end
        wait_trig(lvl, "stv5");
        lvl = ~lvl;
        wait_trig(lvl, "stv6");
        cyc(40);
        exp_seq = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h20, 32'h100};
        for (int k = 0; k < 6; k++) chk($sformatf("stv_grant%0d", k), lg_addr[base + k], exp_seq[k]);
        ack_exp[1] = ~ack_exp[1];
        ack_exp[0] = ~ack_exp[0];
        chk1("stv_ack1", bus.ack_trig_1, ack_exp[1]);
        chk1("stv_ack0", bus.ack_trig_0, ack_exp[0]);
        chk ("stv_rd0", bus.rdata_0, 32'hA5A5_A5A5);

        // Timeout on a silent RAM, then stale drain blocks the next grant
        ram_silent = 1'b1;
        base = log_n;
        lvl  = bus.ram_trig;
        issue(0, 1'b0, 32'h40, 32'h0);
        wait_trig(lvl, "tmo");
        n = 0;
        while (bus.err_timeout !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk ("tmo_cycles", 32'(n), 32'(TMO));
        chk ("tmo_rd0", bus.rdata_0, 32'h0);
        @(negedge clk);
        chk1("tmo_err_pulse", bus.err_timeout, 1'b0);
        chk1("tmo_ack0", bus.ack_trig_0, ~ack_exp[0]);
        ack_exp[0] = ~ack_exp[0];
        ram_silent = 1'b0;
        issue(1, 1'b0, 32'h104, 32'h0);
        cyc(30);
        chk ("stale_no_issue", 32'(log_n - base), 32'd1);
        chk1("stale_no_ack1", bus.ack_trig_1, ack_exp[1]);
        force_req++;
        wait_ack(1, "stale_rd1");
        chk("stale_rd1", bus.rdata_1, 32'hCAFE_F00D);
        chk("stale_ntrig", 32'(log_n - base), 32'd2);
        chk("stale_addr", lg_addr[base + 1], 32'h104);

        // Reset while a transaction is in WAIT
        ram_lat = 10;
        base = log_n;
        lvl  = bus.ram_trig;
        issue(0, 1'b0, 32'h20, 32'h0);
        wait_trig(lvl, "mid");
        cyc(2);
        reset = 1'b1;
        bus.req_trig_0 = 1'b0;
        bus.req_trig_1 = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midrst");
        reset = 1'b0;
        ack_exp[0] = 1'b0; ack_exp[1] = 1'b0;
        cyc(25);
        chk1("midrst_noack0", bus.ack_trig_0, 1'b0);
        chk1("midrst_noack1", bus.ack_trig_1, 1'b0);
        chk ("midrst_ntrig", 32'(log_n - base), 32'd1);

        // Randomized traffic; each port owns a disjoint address window
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        for (int it = 0; it < 30; it++) begin
            ram_lat = int'($urandom_range(1, 8));
            for (int p = 0; p < 2; p++) begin
                go[p] = ($urandom_range(0, 3) != 0);
                if (go[p]) begin
                    rw = 1'($urandom_range(0, 1));
                    a  = ((p == 1) ? 32'h300 : 32'h200) + 32'(4 * $urandom_range(0, 7));
                    wd = $urandom;
                    if (rw) ref_mem[a] = wd;
                    else    exp_rd[p] = ref_mem.exists(a) ? ref_mem[a] : fill_word(a);
                    issue(p, rw, a, wd);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (go[p]) begin
                    wait_ack(p, $sformatf("rnd%0d_p%0d", it, p));
                    chk($sformatf("rnd%0d_rd%0d", it, p), (p == 1) ? bus.rdata_1 : bus.rdata_0, exp_rd[p]);
                end
            end
            cyc(3);
            chk1($sformatf("rnd%0d_ack0", it), bus.ack_trig_0, ack_exp[0]);
            chk1($sformatf("rnd%0d_ack1", it), bus.ack_trig_1, ack_exp[1]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Clocked two-port arbiter that shares the single data RAM between the fetch stage (port 0) and the memory stage (port 1). Each port uses the pipeline's two-phase toggle handshake. The arbiter synchronizes the request toggles, picks one pending port, and runs one RAM transaction with a toggle-request/toggle-done handshake. It then returns read data and toggles that port's acknowledge. Fixed priority goes to the memory stage, with a starvation guard for fetch and a RAM completion timeout.

## Interface
- SYNC_STAGES, 2, flops per toggle synchronizer (≥2)
- MAX_CONSEC, 4, consecutive port-1 grants allowed while port 0 is pending
- TIMEOUT, 1024, cycles in WAIT before forced completion
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_trig_0 / req_trig_1  in  1  request toggle from the port; asynchronous
- addr_0 / addr_1  in  32  address; stable from toggle until ack
- wdata_0 / wdata_1  in  32  store data; stable from toggle until ack
- rw_0 / rw_1  in  1  0 = read, 1 = write; stable from toggle until ack
- rdata_0 / rdata_1  out  32  read result; valid when ack toggles
- ack_trig_0 / ack_trig_1  out  1  acknowledge toggle
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_rw  out  1  RAM direction
- ram_trig  out  1  RAM request toggle
- ram_done  in  1  RAM completion toggle; asynchronous
- ram_rdata  in  32  RAM read data; stable once ram_done toggles
- err_timeout  out  1  one-cycle pulse on forced completion

## Operation
- Reset values: all outputs 0. seen_0 = seen_1 = 0, starve_cnt = 0, wait_cnt = 0, stale = 0, state = IDLE.
- Requester, arbiter and RAM reset together, so all toggle wires restart at 0.
- Pending condition: pending_p = req_s_p XOR seen_p, where req_s_p is req_trig_p after SYNC_STAGES flops.
- A second requester toggle before its ack cancels the request. This is a protocol violation and is not detected.
- Done condition: done_s is ram_done after SYNC_STAGES flops. The transaction is complete when done_s == ram_trig.
- Grant rule, evaluated in IDLE only:
  - Only one port pending: grant that port.
  - Both ports pending: grant port 1, unless starve_cnt == MAX_CONSEC, then grant port 0.
- starve_cnt:
  - Increments on a port-1 grant while pending_0 = 1.
  - Clears on a port-0 grant or on any cycle with pending_0 = 0.
- States:
  - IDLE: if stale = 1, no grant; clear stale when done_s == ram_trig. Otherwise, if any port is pending, latch the grant index and register ram_addr, ram_wdata and ram_rw from that port; go to ISSUE.
  - ISSUE: toggle ram_trig, clear wait_cnt; go to WAIT.
  - WAIT: if done_s == ram_trig, latch ram_rdata into rdata_g (reads only; writes leave rdata_g unchanged) and go to RESP. Otherwise, if wait_cnt == TIMEOUT−1, set rdata_g = 0 for reads, set stale = 1, pulse err_timeout, and go to RESP. Otherwise increment wait_cnt.
  - RESP: toggle ack_trig_g and seen_g; go to IDLE.
- A late RAM completion after a timeout is absorbed by the stale drain in IDLE. The arbiter blocks new grants until that completion arrives.
- Reset in any state returns every register to its reset value on the next edge. An in-flight transaction is abandoned with no ack.

## Timing
- Request latency: from the edge at which req_s_p first differs from seen_p:
  - +1 edge: RAM address/data/direction outputs are registered.
  - +2 edges: ram_trig toggles. Address and data are therefore stable one full cycle before the toggle.
- Completion latency: from the edge at which done_s matches ram_trig:
  - +1 edge: state is RESP and rdata has been captured.
  - +2 edges: ack_trig toggles and state is IDLE.
- Back-to-back: the next grant can occur on the edge after the return to IDLE. Minimum spacing between ram_trig toggles is 4 cycles plus RAM latency plus the synchronizer delay.
- rdata_p changes on the same edge as the RESP entry, one cycle before ack_trig_p toggles. It is held until the next completion for that port.
- Simultaneous requester toggles in the same cycle are resolved by the grant rule. The loser stays pending.

## Structure
- Package ram_arb_pkg:
  - state enum: IDLE, ISSUE, WAIT, RESP
  - PORT_FETCH = 0, PORT_MEM = 1
  - TIMEOUT_RDATA = 32'h0
- Sub-module toggle_sync: a parameterized SYNC_STAGES flop chain with reset value 0. It is instantiated three times (req_trig_0, req_trig_1, ram_done).
- Top level holds the FSM, the grant and starve_cnt logic, the wait_cnt and stale logic, and the output registers.

## Test plan
- Single read: port 1 reads addr 0x100; RAM model toggles done 5 cycles after ram_trig with data 0x12345678. Required: ram_addr = 0x100 and ram_rw = 0 one cycle before ram_trig toggles; rdata_1 = 0x12345678; ack_trig_1 toggles once.
- Write: port 0 writes 0xA5A5A5A5 to 0x20. Required: ram_rw = 1, ram_wdata = 0xA5A5A5A5; rdata_0 is unchanged; ack_trig_0 toggles.
- Contention: both ports toggle in the same cycle. Required: port 1 is served first, then port 0, with exactly two ram_trig toggles.
- Starvation: port 1 re-requests immediately after each ack while port 0 stays pending, MAX_CONSEC = 4. Required: the fifth grant goes to port 0.
- Timeout: TIMEOUT = 16 and the RAM is silent on a port-0 read.
  - Required: 16 cycles after WAIT entry, err_timeout pulses for one cycle, rdata_0 = 0 and ack_trig_0 toggles.
  - Then a port-1 request is not issued until the late ram_done toggle arrives.
- Reset mid-WAIT: assert reset for one cycle during WAIT. Required: all outputs are 0 and state is IDLE after the edge; no ack is produced.
